// File: rtl/ps2_key_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl_if
// Brief    : Signal bundle between the PS/2 byte receiver, the key sequencer
//            and the seven-segment driver.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_ctrl_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
);
    logic                          in_valid;
    logic [7:0]                    in_data;
    logic                          pause;
    logic                          clr;
    logic [31:0]                   disp_data;
    logic [7:0]                    disp_en;
    logic                          key_held;
    logic [CNT_W-1:0]              key_cnt;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    // Byte source / control side
    modport master (
        output in_valid, in_data, pause, clr,
        input  disp_data, disp_en, key_held, key_cnt, overflow, fifo_level
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, pause, clr,
        output disp_data, disp_en, key_held, key_cnt, overflow, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_ctrl
// Brief    : Buffers PS/2 scan-code bytes in a FIFO, decodes the E0/F0
//            prefix protocol, tracks the held key and a press counter, and
//            builds the hex display word and digit enables.
//            Optional macro PS2_REPEAT_CNT_EN: typematic repeats also count.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  wire              clk,
    input  wire              rst,
    ps2_key_ctrl_if.slave    bus
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [7:0] c_PFX_EXT = 8'hE0;
    localparam logic [7:0] c_PFX_BRK = 8'hF0;

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_EXT     = 2'd1;
    localparam logic [1:0] c_S_BRK     = 2'd2;
    localparam logic [1:0] c_S_EXT_BRK = 2'd3;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;

    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [7:0]      w_pop_byte;

    assign w_full     = (r_level == c_LW'(FIFO_DEPTH));
    assign w_pop      = (r_level != '0) && !bus.pause;
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign w_push     = bus.in_valid && (!w_full || w_pop);
    assign w_drop     = bus.in_valid && w_full && !w_pop;
    assign w_pop_byte = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= r_level + c_LW'(w_push) - c_LW'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Prefix decoder FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_make;
    logic       w_brk;
    logic       w_code_ext;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and MAKE/BREAK events for the byte popped this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_make      = 1'b0;
        w_brk       = 1'b0;
        w_code_ext  = 1'b0;
        if (w_pop) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop_byte == c_PFX_EXT) begin
                        w_state_nxt = c_S_EXT;
                    end else if (w_pop_byte == c_PFX_BRK) begin
                        w_state_nxt = c_S_BRK;
                    end else begin
                        w_make = 1'b1;
                    end
                end
                c_S_EXT: begin
                    if (w_pop_byte == c_PFX_BRK) begin
                        w_state_nxt = c_S_EXT_BRK;
                    end else if (w_pop_byte != c_PFX_EXT) begin
                        w_make      = 1'b1;
                        w_code_ext  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_BRK: begin
                    // A stray E0 after F0 resynchronises onto an extended code.
                    if (w_pop_byte == c_PFX_EXT) begin
                        w_state_nxt = c_S_EXT;
                    end else if (w_pop_byte != c_PFX_BRK) begin
                        w_brk       = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
                c_S_EXT_BRK: begin
                    if (w_pop_byte == c_PFX_EXT) begin
                        w_state_nxt = c_S_EXT;
                    end else if (w_pop_byte != c_PFX_BRK) begin
                        w_brk       = 1'b1;
                        w_code_ext  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = c_S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Held-key tracking and press counter
    // ------------------------------------------------------------------
    logic [7:0]       r_held_code;
    logic             r_held_ext;
    logic             r_key_held;
    logic             r_seen_make;
    logic [CNT_W-1:0] r_key_cnt;
    logic             r_overflow;

    logic             w_same;
    logic             w_cnt_inc;

    assign w_same = r_key_held && (w_pop_byte == r_held_code) &&
                    (w_code_ext == r_held_ext);

`ifdef PS2_REPEAT_CNT_EN
    assign w_cnt_inc = w_make;
`else
    assign w_cnt_inc = w_make && !w_same;
`endif

    // Held pair: a new or rolled-over MAKE latches, only a matching BREAK releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_held_code <= '0;
            r_held_ext  <= 1'b0;
            r_key_held  <= 1'b0;
            r_seen_make <= 1'b0;
        end else begin
            if (w_make) begin
                r_seen_make <= 1'b1;
                if (!w_same) begin
                    r_held_code <= w_pop_byte;
                    r_held_ext  <= w_code_ext;
                    r_key_held  <= 1'b1;
                end
            end else if (w_brk && w_same) begin
                r_key_held <= 1'b0;
            end
        end
    end

    // Counter and sticky overflow; clr takes priority over a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clr) begin
            r_key_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_cnt_inc) begin
                r_key_cnt <= r_key_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display word and outputs
    // ------------------------------------------------------------------
    assign bus.disp_data  = {8'h00, r_key_cnt, (r_held_ext ? 8'hE0 : 8'h00), r_held_code};
    assign bus.disp_en    = {2'b00, {2{r_seen_make}}, {2{r_key_held & r_held_ext}},
                             {2{r_key_held}}};
    assign bus.key_held   = r_key_held;
    assign bus.key_cnt    = r_key_cnt;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_level = r_level;

endmodule
`default_nettype wire
